// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant over ALU/LSU/CSR writebacks,
// a registered write port, and a WAW scoreboard that gates issue of busy destinations.
module rf_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_issue_vld,
   input  logic [4:0]  i_issue_rd,
   output logic        o_issue_rdy,
   input  logic        i_flush,
   input  logic [2:0]  i_req_vld,
   input  logic [14:0] i_req_rd,
   input  logic [95:0] i_req_data,
   output logic [2:0]  o_req_rdy,
   output logic        o_wr,
   output logic [4:0]  o_rd,
   output logic [31:0] o_wr_data,
   output logic [31:0] o_busy
);

   typedef enum logic [1:0] {
      PTR_ALU = 2'd0,
      PTR_LSU = 2'd1,
      PTR_CSR = 2'd2
   } ptr_e;

   ptr_e        ptr, ptr_nxt;
   logic        xfer;
   logic [1:0]  gnt_idx;
   logic [1:0]  idx;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;
   logic [31:0] busy_nxt;

   // Grant the first valid requester starting from ptr; nothing is granted under reset or flush.
   always_comb begin
      o_req_rdy = '0;
      xfer      = 1'b0;
      gnt_idx   = 2'd0;
      idx       = 2'd0;
      if (!rst && !i_flush) begin
         for (int unsigned k = 0; k < 3; k++) begin
            idx = 2'((32'(ptr) + k) % 3);
            if (!xfer && i_req_vld[idx]) begin
               xfer           = 1'b1;
               gnt_idx        = idx;
               o_req_rdy[idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_rd   = i_req_rd[4:0];
      sel_data = i_req_data[31:0];
      case (gnt_idx)
         2'd1: begin
            sel_rd   = i_req_rd[9:5];
            sel_data = i_req_data[63:32];
         end
         2'd2: begin
            sel_rd   = i_req_rd[14:10];
            sel_data = i_req_data[95:64];
         end
         default: ;
      endcase
   end

   always_comb begin
      ptr_nxt = ptr;
      if (xfer) begin
         case (gnt_idx)
            2'd0:    ptr_nxt = PTR_LSU;
            2'd1:    ptr_nxt = PTR_CSR;
            default: ptr_nxt = PTR_ALU;
         endcase
      end
   end

   assign o_issue_rdy = i_issue_vld & ~rst & ~i_flush &
                        ((i_issue_rd == '0) | ~o_busy[i_issue_rd]);

   // Set is applied after clear so a same-edge set wins; flush overrides both.
   always_comb begin
      busy_nxt = o_busy;
      if (o_wr)
         busy_nxt[o_rd] = 1'b0;
      if (o_issue_rdy)
         busy_nxt[i_issue_rd] = 1'b1;
      if (i_flush)
         busy_nxt = '0;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= PTR_ALU;
         o_busy    <= '0;
         o_wr      <= 1'b0;
         o_rd      <= '0;
         o_wr_data <= '0;
      end else begin
         ptr    <= ptr_nxt;
         o_busy <= busy_nxt;
         o_wr   <= xfer && (sel_rd != '0);
         if (xfer && (sel_rd != '0)) begin
            o_rd      <= sel_rd;
            o_wr_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: arbitration order, write port timing,
// scoreboard set/clear/flush interplay and reset behaviour.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        i_issue_vld;
   logic [4:0]  i_issue_rd;
   logic        o_issue_rdy;
   logic        i_flush;
   logic [2:0]  i_req_vld;
   logic [14:0] i_req_rd;
   logic [95:0] i_req_data;
   logic [2:0]  o_req_rdy;
   logic        o_wr;
   logic [4:0]  o_rd;
   logic [31:0] o_wr_data;
   logic [31:0] o_busy;

   int n_chk;
   int n_fail;

   rf_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .i_issue_vld(i_issue_vld),
      .i_issue_rd (i_issue_rd),
      .o_issue_rdy(o_issue_rdy),
      .i_flush    (i_flush),
      .i_req_vld  (i_req_vld),
      .i_req_rd   (i_req_rd),
      .i_req_data (i_req_data),
      .o_req_rdy  (o_req_rdy),
      .o_wr       (o_wr),
      .o_rd       (o_rd),
      .o_wr_data  (o_wr_data),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      rst         = 1'b0;
      i_flush     = 1'b0;
      i_issue_vld = 1'b0;
      i_issue_rd  = '0;
      i_req_vld   = '0;
   endtask

   task automatic set_req(input int unsigned n, input logic [4:0] rd, input logic [31:0] data);
      i_req_rd[5*n +: 5]    = rd;
      i_req_data[32*n +: 32] = data;
   endtask

   task automatic issue(input logic [4:0] rd);
      i_issue_vld = 1'b1;
      i_issue_rd  = rd;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      i_req_vld = 3'b111;
      issue(5'd5);
      set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_chk++; if (o_req_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_req_rdy: got %b expected 000", o_req_rdy); end
         n_chk++; if (o_issue_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_issue_rdy: got %b expected 0", o_issue_rdy); end
         edge_step();
      end
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL reset_o_wr: got %b expected 0", o_wr); end
      n_chk++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 00000000", o_busy); end
      n_chk++; if (o_rd !== 5'd0) begin n_fail++; $display("FAIL reset_o_rd: got %0d expected 0", o_rd); end
      n_chk++; if (o_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00000000", o_wr_data); end
      idle();
   endtask

   task automatic test_round_robin();
      logic [4:0]  rr_rd [3];
      logic [31:0] rr_dat[3];
      logic [2:0]  exp_g;
      rr_rd[0] = 5'd1; rr_dat[0] = 32'hA0A0_0001;
      rr_rd[1] = 5'd2; rr_dat[1] = 32'hB0B0_0002;
      rr_rd[2] = 5'd3; rr_dat[2] = 32'hC0C0_0003;
      for (int unsigned n = 0; n < 3; n++) set_req(n, rr_rd[n], rr_dat[n]);
      i_req_vld = 3'b111;
      for (int k = 0; k < 6; k++) begin
         exp_g = 3'b001 << (k % 3);
         @(negedge clk);
         n_chk++; if (o_req_rdy !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, o_req_rdy, exp_g); end
         edge_step();
         n_chk++; if (o_wr !== 1'b1) begin n_fail++; $display("FAIL rr_o_wr[%0d]: got %b expected 1", k, o_wr); end
         n_chk++; if (o_rd !== rr_rd[k % 3]) begin n_fail++; $display("FAIL rr_o_rd[%0d]: got %0d expected %0d", k, o_rd, rr_rd[k % 3]); end
         n_chk++; if (o_wr_data !== rr_dat[k % 3]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, o_wr_data, rr_dat[k % 3]); end
      end
      idle();
      edge_step();
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rr_idle_o_wr: got %b expected 0", o_wr); end
      n_chk++; if (o_rd !== 5'd3) begin n_fail++; $display("FAIL rr_hold_o_rd: got %0d expected 3", o_rd); end
      n_chk++; if (o_wr_data !== 32'hC0C0_0003) begin n_fail++; $display("FAIL rr_hold_data: got %h expected c0c00003", o_wr_data); end
      n_chk++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL rr_busy: got %h expected 00000000", o_busy); end
   endtask

   task automatic test_waw();
      issue(5'd5);
      @(negedge clk);
      n_chk++; if (o_issue_rdy !== 1'b1) begin n_fail++; $display("FAIL waw_first_issue: got %b expected 1", o_issue_rdy); end
      edge_step();
      n_chk++; if (o_busy !== 32'h20) begin n_fail++; $display("FAIL waw_busy_set: got %h expected 00000020", o_busy); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_chk++; if (o_issue_rdy !== 1'b0) begin n_fail++; $display("FAIL waw_stall[%0d]: got %b expected 0", c, o_issue_rdy); end
         edge_step();
      end
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      i_req_vld = 3'b010;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b010) begin n_fail++; $display("FAIL waw_lsu_grant: got %b expected 010", o_req_rdy); end
      n_chk++; if (o_issue_rdy !== 1'b0) begin n_fail++; $display("FAIL waw_stall_req: got %b expected 0", o_issue_rdy); end
      edge_step();
      i_req_vld = 3'b000;
      n_chk++; if (o_wr !== 1'b1 || o_rd !== 5'd5) begin n_fail++; $display("FAIL waw_wb: got wr=%b rd=%0d expected wr=1 rd=5", o_wr, o_rd); end
      n_chk++; if (o_wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL waw_wb_data: got %h expected deadbeef", o_wr_data); end
      @(negedge clk);
      n_chk++; if (o_issue_rdy !== 1'b0) begin n_fail++; $display("FAIL waw_stall_wb: got %b expected 0", o_issue_rdy); end
      edge_step();
      n_chk++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL waw_busy_clear: got %h expected 00000000", o_busy); end
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL waw_single_wr: got %b expected 0", o_wr); end
      @(negedge clk);
      n_chk++; if (o_issue_rdy !== 1'b1) begin n_fail++; $display("FAIL waw_reissue: got %b expected 1", o_issue_rdy); end
      edge_step();
      n_chk++; if (o_busy !== 32'h20) begin n_fail++; $display("FAIL waw_reissue_busy: got %h expected 00000020", o_busy); end
      idle();
      i_flush = 1'b1;
      edge_step();
      idle();
   endtask

   task automatic test_rd_zero();
      issue(5'd9);
      edge_step();
      idle();
      n_chk++; if (o_busy !== 32'h200) begin n_fail++; $display("FAIL rd0_pre_busy: got %h expected 00000200", o_busy); end
      set_req(0, 5'd0, 32'h0000_1234);
      i_req_vld = 3'b001;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b001) begin n_fail++; $display("FAIL rd0_grant: got %b expected 001", o_req_rdy); end
      edge_step();
      idle();
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rd0_no_write: got %b expected 0", o_wr); end
      n_chk++; if (o_busy !== 32'h200) begin n_fail++; $display("FAIL rd0_busy: got %h expected 00000200", o_busy); end
   endtask

   task automatic test_same_edge();
      set_req(0, 5'd7, 32'h7777_7777);
      i_req_vld = 3'b001;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b001) begin n_fail++; $display("FAIL se_grant: got %b expected 001", o_req_rdy); end
      edge_step();
      idle();
      issue(5'd7);
      @(negedge clk);
      n_chk++; if (o_wr !== 1'b1 || o_rd !== 5'd7) begin n_fail++; $display("FAIL se_wb: got wr=%b rd=%0d expected wr=1 rd=7", o_wr, o_rd); end
      n_chk++; if (o_issue_rdy !== 1'b1) begin n_fail++; $display("FAIL se_issue_rdy: got %b expected 1", o_issue_rdy); end
      edge_step();
      idle();
      n_chk++; if (o_busy !== 32'h280) begin n_fail++; $display("FAIL se_busy_set_wins: got %h expected 00000280", o_busy); end
      set_req(1, 5'd9, 32'h9999_9999);
      i_req_vld = 3'b010;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b010) begin n_fail++; $display("FAIL se_lsu_grant: got %b expected 010", o_req_rdy); end
      edge_step();
      idle();
      edge_step();
      n_chk++; if (o_busy !== 32'h80) begin n_fail++; $display("FAIL se_clear9: got %h expected 00000080", o_busy); end
   endtask

   task automatic test_flush();
      issue(5'd3);  edge_step();
      issue(5'd9);  edge_step();
      issue(5'd31); edge_step();
      idle();
      n_chk++; if (o_busy !== 32'h8000_0288) begin n_fail++; $display("FAIL fl_busy_pre: got %h expected 80000288", o_busy); end
      set_req(2, 5'd4, 32'h4444_4444);
      i_req_vld = 3'b100;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b100) begin n_fail++; $display("FAIL fl_csr_grant: got %b expected 100", o_req_rdy); end
      edge_step();
      i_flush   = 1'b1;
      i_req_vld = 3'b111;
      issue(5'd12);
      @(negedge clk);
      n_chk++; if (o_issue_rdy !== 1'b0) begin n_fail++; $display("FAIL fl_issue_rdy: got %b expected 0", o_issue_rdy); end
      n_chk++; if (o_req_rdy !== 3'b000) begin n_fail++; $display("FAIL fl_req_rdy: got %b expected 000", o_req_rdy); end
      n_chk++; if (o_wr !== 1'b1 || o_rd !== 5'd4) begin n_fail++; $display("FAIL fl_wb_completes: got wr=%b rd=%0d expected wr=1 rd=4", o_wr, o_rd); end
      edge_step();
      idle();
      n_chk++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL fl_busy_clear: got %h expected 00000000", o_busy); end
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL fl_o_wr: got %b expected 0", o_wr); end
   endtask

   task automatic test_reset_midflight();
      set_req(0, 5'd8, 32'h8888_8888);
      i_req_vld = 3'b001;
      issue(5'd10);
      edge_step();
      idle();
      n_chk++; if (o_busy !== 32'h400) begin n_fail++; $display("FAIL rm_busy10: got %h expected 00000400", o_busy); end
      set_req(2, 5'd6, 32'hC5C5_C5C5);
      i_req_vld = 3'b100;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b100) begin n_fail++; $display("FAIL rm_csr_grant: got %b expected 100", o_req_rdy); end
      edge_step();
      idle();
      rst = 1'b1;
      set_req(1, 5'd11, 32'hBBBB_BBBB);
      i_req_vld = 3'b010;
      issue(5'd11);
      @(negedge clk);
      n_chk++; if (o_wr !== 1'b1 || o_rd !== 5'd6) begin n_fail++; $display("FAIL rm_inflight: got wr=%b rd=%0d expected wr=1 rd=6", o_wr, o_rd); end
      n_chk++; if (o_req_rdy !== 3'b000) begin n_fail++; $display("FAIL rm_rst_req_rdy: got %b expected 000", o_req_rdy); end
      n_chk++; if (o_issue_rdy !== 1'b0) begin n_fail++; $display("FAIL rm_rst_issue_rdy: got %b expected 0", o_issue_rdy); end
      edge_step();
      idle();
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rm_o_wr: got %b expected 0", o_wr); end
      n_chk++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL rm_busy: got %h expected 00000000", o_busy); end
      n_chk++; if (o_rd !== 5'd0 || o_wr_data !== 32'h0) begin n_fail++; $display("FAIL rm_port_clear: got rd=%0d data=%h expected rd=0 data=00000000", o_rd, o_wr_data); end
      edge_step();
      n_chk++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rm_no_stray_wr: got %b expected 0", o_wr); end
      set_req(1, 5'd13, 32'h0000_000D);
      i_req_vld = 3'b010;
      edge_step();
      idle();
      rst = 1'b1;
      edge_step();
      idle();
      for (int unsigned n = 0; n < 3; n++) set_req(n, 5'(n + 1), 32'h5000_0000 + n);
      i_req_vld = 3'b111;
      @(negedge clk);
      n_chk++; if (o_req_rdy !== 3'b001) begin n_fail++; $display("FAIL rm_ptr_reset_grant: got %b expected 001", o_req_rdy); end
      edge_step();
      idle();
      n_chk++; if (o_wr !== 1'b1 || o_rd !== 5'd1) begin n_fail++; $display("FAIL rm_post_wb: got wr=%b rd=%0d expected wr=1 rd=1", o_wr, o_rd); end
      n_chk++; if (o_busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy0_zero: got %b expected 0", o_busy[0]); end
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      i_req_rd   = '0;
      i_req_data = '0;
      idle();
      test_reset();
      test_round_robin();
      test_waw();
      test_rd_zero();
      test_same_edge();
      test_flush();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
